divider_pipe_param: RTL and testbench

//  Parametrised pipelined integer divider: restoring radix-2, one bit per step, STEPS steps per register stage.

---
 rtl/divp_pkg.sv | 28 ++
 rtl/divp_stage.sv | 56 +++++
 rtl/divider_pipe_param.sv | 136 +++++++++++++
 tb/tb_divider_pipe_param.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divp_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
package divp_pkg;

  localparam int DIVP_MAX_W     = 64;
  localparam int DIVP_TAG_MAX_W = 16;

  typedef struct packed {
    logic                      valid;
    logic                      sgn;
    logic                      neg_q;
    logic                      neg_r;
    logic                      dz;
    logic                      ovf;
    logic [DIVP_TAG_MAX_W-1:0] tag;
  } divp_op_t;

  function automatic logic [DIVP_MAX_W-1:0] cond_neg(input logic [DIVP_MAX_W-1:0] x,
                                                     input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  // Magnitude of a w-bit value held zero-extended in x; callers keep the low w bits.
  function automatic logic [DIVP_MAX_W-1:0] abs_val(input logic [DIVP_MAX_W-1:0] x,
                                                    input int w, input logic sgn);
    return cond_neg(x, sgn & x[w-1]);
  endfunction

endpackage

// File: rtl/divp_stage.sv
// One divider register stage: STEPS cascaded restoring steps feeding a register bank.
module divp_stage
  import divp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv,
  input  logic             flush,
  input  divp_op_t         op,
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsr,
  output divp_op_t         op_r,
  output logic [WIDTH-1:0] rem_r,
  output logic [WIDTH-1:0] quo_r,
  output logic [WIDTH-1:0] dsr_r
);

  // quo starts as the dividend; its MSBs shift into rem while quotient bits fill from the bottom.
  logic [WIDTH-1:0] r_s [STEPS+1];
  logic [WIDTH-1:0] q_s [STEPS+1];

  assign r_s[0] = rem;
  assign q_s[0] = quo;

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    logic [WIDTH:0] sh;
    logic           ge;
    assign sh         = {r_s[k], q_s[k][WIDTH-1]};
    assign ge         = sh >= {1'b0, dsr};
    // Either result is below the divisor, so it fits back into WIDTH bits.
    assign r_s[k+1]   = ge ? WIDTH'(sh - {1'b0, dsr}) : sh[WIDTH-1:0];
    assign q_s[k+1]   = {q_s[k][WIDTH-2:0], ge};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_r  <= '0;
      rem_r <= '0;
      quo_r <= '0;
      dsr_r <= '0;
    end else begin
      if (adv) begin
        op_r  <= op;
        rem_r <= r_s[STEPS];
        quo_r <= q_s[STEPS];
        dsr_r <= dsr;
      end
      if (flush) op_r.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/divider_pipe_param.sv
// Pipelined radix-2 restoring divider with RISC-V special cases and valid/ready flow control.
// Optional DIVP_EXC_FLAGS_EN adds dz_o / ovf_o result flags.
module divider_pipe_param
  import divp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [TAG_W-1:0] tag_o
`ifdef DIVP_EXC_FLAGS_EN
  ,
  output logic             dz_o,
  output logic             ovf_o
`endif
);

  localparam int               NSTG    = WIDTH / STEPS;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic adv, so_valid;
  assign adv         = !so_valid || out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = so_valid;

  // S0: magnitudes, sign fix-up info and special-case flags
  divp_op_t              s0_n, s0_op;
  logic [WIDTH-1:0]      s0_q, s0_d;
  logic [DIVP_MAX_W-1:0] a_abs_w, b_abs_w;

  assign a_abs_w = abs_val(DIVP_MAX_W'(dividend_i), WIDTH, signed_i);
  assign b_abs_w = abs_val(DIVP_MAX_W'(divisor_i), WIDTH, signed_i);

  always_comb begin
    s0_n       = '0;
    s0_n.valid = in_valid_i && !flush_i;
    s0_n.sgn   = signed_i;
    s0_n.neg_q = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
    s0_n.neg_r = signed_i & dividend_i[WIDTH-1];
    s0_n.dz    = (divisor_i == '0);
    s0_n.ovf   = signed_i && (dividend_i == MIN_VAL) && (&divisor_i);
    s0_n.tag   = DIVP_TAG_MAX_W'(tag_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s0_op <= '0;
      s0_q  <= '0;
      s0_d  <= '0;
    end else begin
      if (adv) begin
        s0_op <= s0_n;
        s0_q  <= a_abs_w[WIDTH-1:0];
        s0_d  <= b_abs_w[WIDTH-1:0];
      end
      if (flush_i) s0_op.valid <= 1'b0;
    end
  end

  divp_op_t         op_c [NSTG+1];
  logic [WIDTH-1:0] r_c  [NSTG+1];
  logic [WIDTH-1:0] q_c  [NSTG+1];
  logic [WIDTH-1:0] d_c  [NSTG+1];

  assign op_c[0] = s0_op;
  assign r_c[0]  = '0;
  assign q_c[0]  = s0_q;
  assign d_c[0]  = s0_d;

  for (genvar i = 0; i < NSTG; i++) begin : g_stg
    divp_stage #(.WIDTH(WIDTH), .STEPS(STEPS)) u_stg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .adv   (adv),
      .flush (flush_i),
      .op    (op_c[i]),
      .rem   (r_c[i]),
      .quo   (q_c[i]),
      .dsr   (d_c[i]),
      .op_r  (op_c[i+1]),
      .rem_r (r_c[i+1]),
      .quo_r (q_c[i+1]),
      .dsr_r (d_c[i+1])
    );
  end

  // SO: sign fix and special-case override. With a zero divisor the datapath
  // remainder equals |dividend|, so the sign fix alone restores the dividend.
  divp_op_t              fin;
  logic [DIVP_MAX_W-1:0] q_fix_w, r_fix_w;

  assign fin     = op_c[NSTG];
  assign q_fix_w = cond_neg(DIVP_MAX_W'(q_c[NSTG]), fin.neg_q);
  assign r_fix_w = cond_neg(DIVP_MAX_W'(r_c[NSTG]), fin.neg_r);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      so_valid <= 1'b0;
      quo_o    <= '0;
      rem_o    <= '0;
      tag_o    <= '0;
`ifdef DIVP_EXC_FLAGS_EN
      dz_o     <= 1'b0;
      ovf_o    <= 1'b0;
`endif
    end else begin
      if (adv) begin
        so_valid <= fin.valid;
        if (fin.dz)                quo_o <= '1;
        else if (fin.ovf && fin.sgn) quo_o <= MIN_VAL;
        else                       quo_o <= q_fix_w[WIDTH-1:0];
        rem_o <= (fin.ovf && fin.sgn) ? '0 : r_fix_w[WIDTH-1:0];
        tag_o <= fin.tag[TAG_W-1:0];
`ifdef DIVP_EXC_FLAGS_EN
        dz_o  <= fin.dz;
        ovf_o <= fin.ovf;
`endif
      end
      if (flush_i) so_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_pipe_param.sv
// Directed bench for divider_pipe_param (32-bit default instance plus an 8-bit/2-step instance).
module tb_divider_pipe_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sg, flush, out_valid, out_ready;
  logic [31:0] dvd, dvs, quo, rem;
  logic [4:0]  tag, tag_o;
  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  dvd8, dvs8, quo8, rem8;
  logic [4:0]  tag8, tag_o8;
`ifdef DIVP_EXC_FLAGS_EN
  logic        dz, ovf, dz8, ovf8, last_dz, last_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divider_pipe_param #(.WIDTH(32), .STEPS(4), .TAG_W(5)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .signed_i(sg), .dividend_i(dvd), .divisor_i(dvs), .tag_i(tag), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .quo_o(quo), .rem_o(rem), .tag_o(tag_o)
`ifdef DIVP_EXC_FLAGS_EN
    , .dz_o(dz), .ovf_o(ovf)
`endif
  );

  divider_pipe_param #(.WIDTH(8), .STEPS(2), .TAG_W(5)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .signed_i(sg), .dividend_i(dvd8), .divisor_i(dvs8), .tag_i(tag8), .flush_i(flush),
    .out_valid_o(out_valid8), .out_ready_i(out_ready), .quo_o(quo8), .rem_o(rem8), .tag_o(tag_o8)
`ifdef DIVP_EXC_FLAGS_EN
    , .dz_o(dz8), .ovf_o(ovf8)
`endif
  );

  typedef struct {
    logic        s;
    logic [31:0] a, b, q, r;
    logic        dz, ovf;
  } vec_t;

  function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a; sb = b;
    if (b == 0) begin q = '1; r = a; end
    else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = a; r = 0; end
    else if (s) begin q = sa / sb; r = sa % sb; end
    else begin q = a / b; r = a % b; end
    return {q, r};
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0] sa, sb;
    logic [7:0] q, r;
    sa = a; sb = b;
    if (b == 0) begin q = '1; r = a; end
    else if (s && a == 8'h80 && b == 8'hFF) begin q = a; r = 0; end
    else if (s) begin q = sa / sb; r = sa % sb; end
    else begin q = a / b; r = a % b; end
    return {q, r};
  endfunction

  // Issues one op (pipe idle, out_ready high) and waits, bounded, for its result.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                       output logic [31:0] q, output logic [31:0] r, output logic [4:0] tg, output int lat);
    sg = s; dvd = a; dvs = b; tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    q = quo; r = rem; tg = tag_o;
`ifdef DIVP_EXC_FLAGS_EN
    last_dz = dz; last_ovf = ovf;
`endif
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL op_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_valid8 = 0; flush = 0; out_ready = 1; sg = 0;
    dvd = 0; dvs = 0; tag = 0; dvd8 = 0; dvs8 = 0; tag8 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL reset_hs: valid/ready=%b required 01", {out_valid, in_ready});
    end
    n_cmp++;
    if ({quo, rem, tag_o} !== 69'd0) begin
      n_err++; $display("FAIL reset_data: quo=%h rem=%h tag=%h required 0", quo, rem, tag_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] q, r; logic [4:0] t; int lat;
    do_op(1'b0, 32'd100, 32'd7, 5'd3, q, r, t, lat);
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL latency: got %0d required 10", lat); end
    n_cmp++;
    if ({q, r, t} !== {32'd14, 32'd2, 5'd3}) begin
      n_err++; $display("FAIL basic_100_7: q=%h r=%h tag=%h required 0000000e/00000002/03", q, r, t);
    end
  endtask

  task automatic test_special();
    vec_t v[9];
    logic [31:0] q, r; logic [4:0] t; int lat;
    v[0] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
    v[1] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0};
    v[2] = '{1'b0, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1,        1'b0, 1'b0};
    v[3] = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
    v[4] = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
    v[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1};
    v[6] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0};
    v[7] = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0};
    v[8] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_op(v[i].s, v[i].a, v[i].b, 5'(i), q, r, t, lat);
      n_cmp++;
      if ({q, r, t} !== {v[i].q, v[i].r, 5'(i)}) begin
        n_err++;
        $display("FAIL special_%0d: q=%h r=%h tag=%h required %h/%h/%h", i, q, r, t, v[i].q, v[i].r, 5'(i));
      end
`ifdef DIVP_EXC_FLAGS_EN
      n_cmp++;
      if ({last_dz, last_ovf} !== {v[i].dz, v[i].ovf}) begin
        n_err++;
        $display("FAIL flags_%0d: dz/ovf=%b%b required %b%b", i, last_dz, last_ovf, v[i].dz, v[i].ovf);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [68:0] exp_q[$];
    logic [68:0] e;
    int issued = 0, got = 0, gaps = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 1030; c++) begin
      if (out_valid) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: unexpected result q=%h", quo);
        end else begin
          e = exp_q.pop_front();
          if ({quo, rem, tag_o} !== e) begin
            n_err++; $display("FAIL b2b_data: got %h/%h/%h required %h/%h/%h",
                              quo, rem, tag_o, e[68:37], e[36:5], e[4:0]);
          end
        end
      end else if (got > 0 && got < 1000) gaps++;
      if (issued < 1000) begin
        sg  = 1'($urandom_range(0, 1));
        dvd = $urandom;
        case ($urandom_range(0, 9))
          0:       dvs = 0;
          1, 2, 3: dvs = $urandom_range(1, 20);
          4:       dvs = -$urandom_range(1, 20);
          default: dvs = $urandom >> $urandom_range(0, 31);
        endcase
        tag = 5'(issued);
        in_valid = 1'b1;
        exp_q.push_back({ref32(sg, dvd, dvs), tag});
        issued++;
      end else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got !== 1000 || gaps !== 0) begin
      n_err++; $display("FAIL b2b_rate: results=%0d gaps=%0d required 1000/0", got, gaps);
    end
  endtask

  task automatic test_stall();
    logic [68:0] exp_q[$];
    logic [68:0] e, held;
    int issued = 0, got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (in_ready) begin
        sg = 0; dvd = 1000 + c * 37; dvs = c + 3; tag = 5'(c + 1); in_valid = 1'b1;
        exp_q.push_back({ref32(1'b0, dvd, dvs), tag});
        issued++;
      end else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (issued !== 10) begin n_err++; $display("FAIL stall_depth: accepted %0d required 10", issued); end
    held = {quo, rem, tag_o};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {quo, rem, tag_o} !== held) begin
        n_err++; $display("FAIL stall_hold: ready=%b valid=%b q=%h required 0/1/%h",
                          in_ready, out_valid, quo, held[68:37]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stall_dup: extra result tag=%h", tag_o);
        end else begin
          e = exp_q.pop_front();
          if ({quo, rem, tag_o} !== e) begin
            n_err++; $display("FAIL stall_order: got tag=%h q=%h required tag=%h q=%h",
                              tag_o, quo, e[4:0], e[68:37]);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got !== issued) begin n_err++; $display("FAIL stall_count: got %0d required %0d", got, issued); end
  endtask

  task automatic test_flush();
    logic [31:0] q, r; logic [4:0] t; int lat, seen = 0, w = 0;
    for (int c = 0; c < 4; c++) begin
      sg = 0; dvd = 500 + c; dvs = 3; tag = 5'(20 + c); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    dvd = 77; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL flush_kill: %0d results emerged, required 0", seen); end
    do_op(1'b1, 32'hFFFFFF9C, 32'd7, 5'd9, q, r, t, lat);
    n_cmp++;
    if ({q, r, t} !== {32'hFFFFFFF2, 32'hFFFFFFFE, 5'd9}) begin
      n_err++; $display("FAIL flush_after: q=%h r=%h tag=%h required fffffff2/fffffffe/09", q, r, t);
    end
    @(posedge clk); #1;
    // flush while a result is stalled at the output
    out_ready = 1'b0;
    sg = 0; dvd = 9; dvs = 2; tag = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && w < 30) begin @(posedge clk); #1; w++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01 || w >= 30) begin
      n_err++; $display("FAIL flush_stall: valid/ready=%b wait=%0d required 01", {out_valid, in_ready}, w);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_width8();
    logic [20:0] exp_q[$];
    logic [20:0] e;
    logic [7:0]  sa[8] = '{8'h80, 8'hF9, 8'hFF, 8'h05, 8'hC8, 8'h07, 8'h80, 8'h81};
    logic [7:0]  sb[8] = '{8'hFF, 8'h02, 8'h02, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'h7F};
    logic        ss[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int issued = 0, got = 0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid8) begin
        got++;
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 21'h1FFFFF;
        if ({quo8, rem8, tag_o8} !== e) begin
          n_err++; $display("FAIL w8_data: got %h/%h/%h required %h/%h/%h",
                            quo8, rem8, tag_o8, e[20:13], e[12:5], e[4:0]);
        end
      end
      if (issued < 60) begin
        if (issued < 8) begin sg = ss[issued]; dvd8 = sa[issued]; dvs8 = sb[issued]; end
        else begin sg = 1'($urandom_range(0, 1)); dvd8 = 8'($urandom); dvs8 = 8'($urandom); end
        tag8 = 5'(issued);
        in_valid8 = 1'b1;
        exp_q.push_back({ref8(sg, dvd8, dvs8), tag8});
        issued++;
      end else in_valid8 = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got !== 60) begin n_err++; $display("FAIL w8_count: got %0d required 60", got); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    for (int c = 0; c < 12; c++) begin
      sg = 0; dvd = 5000 + c; dvs = 3; tag = 5'(c + 1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: valid=%b required 1", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, quo, rem, tag_o} !== 70'd0) begin
      n_err++; $display("FAIL rstmid_async: valid=%b q=%h r=%h tag=%h required all 0", out_valid, quo, rem, tag_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL rstmid_leak: %0d results after reset, required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_stall();
    test_flush();
    test_width8();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
